// File: rtl/f11_vic_pkg.sv
// Shared state codes, level base and fast-input word layout for the F-11 vectored interrupt controller.
package f11_vic_pkg;

  typedef logic [2:0] vic_state_t;

  localparam vic_state_t ST_IDLE  = 3'd0;
  localparam vic_state_t ST_LATCH = 3'd1;
  localparam vic_state_t ST_FDIN  = 3'd2;
  localparam vic_state_t ST_ACK   = 3'd3;
  localparam vic_state_t ST_WAIT  = 3'd4;

  // Level code k on a source maps to CPU request line BR(LVL_BASE+k).
  localparam int LVL_BASE = 4;

  localparam int FDIN_START_LSB = 8;
  localparam int FDIN_HALT_BIT  = 2;

  function automatic logic [15:0] fdin_word(input logic [7:0] boot_hi, input logic halt_trap);
    logic [15:0] w;
    w = '0;
    w[FDIN_START_LSB +: 8] = boot_hi;
    w[FDIN_HALT_BIT]       = halt_trap;
    return w;
  endfunction

endpackage

// File: rtl/f11_vic_arb.sv
// Combinational priority encoder: highest level wins, lowest index breaks ties; also ORs requests per level.
// Zero latency, no flow control (pure function of req/lvl).
module f11_vic_arb #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] lvl,
  output logic [IW-1:0]  win,
  output logic           valid,
  output logic [3:0]     lvl_or
);

  logic [1:0] best;

  // Scanning from the top index with >= lets a lower index displace an equal-level winner.
  always_comb begin
    win    = '0;
    valid  = 1'b0;
    lvl_or = '0;
    best   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lvl_or[lvl[2*i +: 2]] = 1'b1;
        if (!valid || (lvl[2*i +: 2] >= best)) begin
          best  = lvl[2*i +: 2];
          win   = i[IW-1:0];
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/f11_vic.sv
// Vectored interrupt controller: per-level request lines, vector/fast-input answer to CPU strobes.
// Ack two cycles after strobe is seen; strobe must drop before the next cycle is accepted.
module f11_vic
  import f11_vic_pkg::*;
#(
  parameter int          N_IRQ     = 8,
  parameter logic [7:0]  BOOT_HI   = 8'o366,
  parameter logic        HALT_TRAP = 1'b0,
  parameter logic [15:0] STRAY_VEC = 16'o000000
) (
  input  logic                           vm_clk_p,
  input  logic                           vm_init,
  input  logic [N_IRQ-1:0]               irq_req,
  input  logic [2*N_IRQ-1:0]             irq_lvl,
  input  logic [8*N_IRQ-1:0]             irq_vec,
  output logic [N_IRQ-1:0]               irq_ack,
  output logic [LVL_BASE+3:LVL_BASE]     vm_virq,
  input  logic                           wbi_stb_i,
  input  logic                           wbi_una_i,
  output logic [15:0]                    wbi_dat_o,
  output logic                           wbi_ack_o
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  vic_state_t       state;
  logic [IW-1:0]    arb_win;
  logic             arb_valid;
  logic [3:0]       lvl_or;
  logic [IW-1:0]    win_q;
  logic             valid_q;
  logic             fd_q;
  logic [7:0]       vec_sel;
  logic [N_IRQ-1:0] ack_1h;

  f11_vic_arb #(.N(N_IRQ), .IW(IW)) u_arb (
    .req    (irq_req),
    .lvl    (irq_lvl),
    .win    (arb_win),
    .valid  (arb_valid),
    .lvl_or (lvl_or)
  );

  always_comb begin
    vec_sel = '0;
    ack_1h  = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (win_q == i[IW-1:0]) begin
        vec_sel   = irq_vec[8*i +: 8];
        ack_1h[i] = valid_q;
      end
    end
  end

  always_ff @(posedge vm_clk_p) begin
    if (vm_init) begin
      state     <= ST_IDLE;
      win_q     <= '0;
      valid_q   <= 1'b0;
      fd_q      <= 1'b0;
      vm_virq   <= '0;
      irq_ack   <= '0;
      wbi_ack_o <= 1'b0;
      wbi_dat_o <= '0;
    end else begin
      vm_virq   <= lvl_or;
      wbi_ack_o <= 1'b0;
      irq_ack   <= '0;
      case (state)
        ST_IDLE: begin
          if (wbi_stb_i) begin
            fd_q  <= wbi_una_i;
            state <= wbi_una_i ? ST_FDIN : ST_LATCH;
          end
        end
        ST_LATCH: begin
          win_q   <= arb_win;
          valid_q <= arb_valid;
          state   <= ST_ACK;
        end
        ST_FDIN: begin
          wbi_dat_o <= fdin_word(BOOT_HI, HALT_TRAP);
          state     <= ST_ACK;
        end
        ST_ACK: begin
          wbi_ack_o <= 1'b1;
          if (!fd_q) begin
            if (valid_q) begin
              wbi_dat_o <= {6'b0, vec_sel, 2'b00};
              irq_ack   <= ack_1h;
            end else begin
              wbi_dat_o <= STRAY_VEC;
            end
          end
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A strobe still high here belongs to the cycle just answered.
          if (!wbi_stb_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f11_vic.sv
// Directed bench for f11_vic: cycle-level behavioural model plus hand-computed expectations.
module tb_f11_vic;

  logic        clk;
  logic        vm_init;
  logic [7:0]  irq_req;
  logic [15:0] irq_lvl;
  logic [63:0] irq_vec;
  logic        stb;
  logic        una;

  logic [7:0]  iack, iack_ht;
  logic [7:4]  virq, virq_ht;
  logic [15:0] dat, dat_ht;
  logic        ack, ack_ht;

  int checks   = 0;
  int failures = 0;

  f11_vic dut (
    .vm_clk_p (clk), .vm_init (vm_init),
    .irq_req (irq_req), .irq_lvl (irq_lvl), .irq_vec (irq_vec),
    .irq_ack (iack), .vm_virq (virq),
    .wbi_stb_i (stb), .wbi_una_i (una),
    .wbi_dat_o (dat), .wbi_ack_o (ack)
  );

  f11_vic #(.HALT_TRAP(1'b1)) dut_ht (
    .vm_clk_p (clk), .vm_init (vm_init),
    .irq_req (irq_req), .irq_lvl (irq_lvl), .irq_vec (irq_vec),
    .irq_ack (iack_ht), .vm_virq (virq_ht),
    .wbi_stb_i (stb), .wbi_una_i (una),
    .wbi_dat_o (dat_ht), .wbi_ack_o (ack_ht)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transaction starts when an idle controller sees the strobe,
  // the winner is chosen one edge later, the answer appears two edges later.
  logic        m_rst, m_busy, m_wait, m_fd, m_ack;
  int          m_age, m_win;
  logic [3:0]  m_virq;
  logic [7:0]  m_iack;
  logic [15:0] m_dat, m_dat_ht;

  initial begin
    m_rst = 1'b1; m_busy = 1'b0; m_wait = 1'b0; m_fd = 1'b0; m_ack = 1'b0;
    m_age = 0; m_win = -1; m_virq = '0; m_iack = '0; m_dat = '0; m_dat_ht = '0;
    forever begin
      @(posedge clk);
      if (vm_init) begin
        m_rst = 1'b1; m_busy = 1'b0; m_wait = 1'b0; m_ack = 1'b0;
        m_iack = '0; m_virq = '0; m_dat = '0; m_dat_ht = '0;
      end else begin
        m_rst  = 1'b0;
        m_ack  = 1'b0;
        m_iack = '0;
        m_virq = '0;
        for (int i = 0; i < 8; i++)
          if (irq_req[i]) m_virq = m_virq | (4'b0001 << irq_lvl[2*i +: 2]);
        if (m_busy) begin
          m_age++;
          if (m_age == 1 && !m_fd) begin
            int maxl;
            maxl  = -1;
            m_win = -1;
            for (int i = 0; i < 8; i++)
              if (irq_req[i] && int'(irq_lvl[2*i +: 2]) > maxl) maxl = int'(irq_lvl[2*i +: 2]);
            for (int i = 0; i < 8; i++)
              if (m_win < 0 && irq_req[i] && int'(irq_lvl[2*i +: 2]) == maxl) m_win = i;
          end
          if (m_age == 2) begin
            m_ack  = 1'b1;
            m_busy = 1'b0;
            m_wait = 1'b1;
            if (m_fd) begin
              m_dat    = 16'(8'o366) << 8;
              m_dat_ht = (16'(8'o366) << 8) | 16'd4;
            end else if (m_win >= 0) begin
              logic [63:0] t;
              t        = irq_vec >> (8 * m_win);
              m_dat    = 16'(t[7:0]) * 16'd4;
              m_dat_ht = m_dat;
              m_iack   = 8'd1 << m_win;
            end else begin
              m_dat    = 16'o000000;
              m_dat_ht = 16'o000000;
            end
          end
        end else if (m_wait) begin
          if (!stb) m_wait = 1'b0;
        end else if (stb) begin
          m_busy = 1'b1;
          m_age  = 0;
          m_fd   = una;
        end
      end
      #1;
      chk("virq", 32'(virq), 32'(m_virq));
      chk("wbi_ack", 32'(ack), 32'(m_ack));
      chk("irq_ack", 32'(iack), 32'(m_iack));
      chk("wbi_ack_ht", 32'(ack_ht), 32'(m_ack));
      chk("irq_ack_ht", 32'(iack_ht), 32'(m_iack));
      if (m_ack || m_rst) begin
        chk("wbi_dat", 32'(dat), 32'(m_dat));
        chk("wbi_dat_ht", 32'(dat_ht), 32'(m_dat_ht));
      end
    end
  end

  // One CPU cycle: raise strobe, optionally withdraw requests before the latch edge,
  // record the first ack, and count acks over a 12-cycle window.
  task automatic bus(input logic u, input logic [7:0] drop_mask, input logic hold,
                     output int lat, output int nacks, output logic [15:0] d,
                     output logic [15:0] d_ht, output logic [7:0] ia);
    @(negedge clk);
    stb = 1'b1; una = u;
    lat = 0; nacks = 0; d = '0; d_ht = '0; ia = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) irq_req = irq_req & ~drop_mask;
      if (ack) begin
        nacks++;
        if (nacks == 1) begin
          lat = c; d = dat; d_ht = dat_ht; ia = iack;
          irq_req = irq_req & ~iack;
          if (!hold) stb = 1'b0;
        end
      end
    end
    stb = 1'b0; una = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int          lat, nacks, nres;
  logic [15:0] d, d_ht;
  logic [7:0]  ia;

  initial begin
    vm_init = 1'b1; stb = 1'b0; una = 1'b0;
    irq_req = 8'hFF; irq_lvl = '0; irq_vec = '0;
    repeat (3) @(negedge clk);
    chk("rst_virq", 32'(virq), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_irq_ack", 32'(iack), 32'h0);
    chk("rst_dat", 32'(dat), 32'h0);
    vm_init = 1'b0;
    @(negedge clk);
    chk("post_rst_virq", 32'(virq), 32'b0001);
    irq_req = '0;
    repeat (2) @(negedge clk);

    // Single request at BR5
    irq_lvl[6 +: 2] = 2'b01; irq_vec[24 +: 8] = 8'o017; irq_req[3] = 1'b1;
    repeat (2) @(negedge clk);
    chk("single_virq", 32'(virq), 32'b0010);
    bus(1'b0, 8'h00, 1'b0, lat, nacks, d, d_ht, ia);
    chk("single_lat", 32'(lat), 32'd3);
    chk("single_dat", 32'(d), 32'(16'o000074));
    chk("single_irq_ack", 32'(ia), 32'h08);
    chk("single_nacks", 32'(nacks), 32'd1);
    chk("single_virq_drop", 32'(virq), 32'h0);

    // Priority: 1 and 5 at BR7, 0 at BR4
    irq_lvl[2 +: 2] = 2'b11; irq_lvl[10 +: 2] = 2'b11; irq_lvl[0 +: 2] = 2'b00;
    irq_vec[8 +: 8] = 8'h21; irq_vec[40 +: 8] = 8'h55; irq_vec[0 +: 8] = 8'h0A;
    irq_req = 8'b0010_0011;
    bus(1'b0, 8'h00, 1'b0, lat, nacks, d, d_ht, ia);
    chk("prio1_irq_ack", 32'(ia), 32'h02);
    chk("prio1_dat", 32'(d), 32'h0084);
    bus(1'b0, 8'h00, 1'b0, lat, nacks, d, d_ht, ia);
    chk("prio5_irq_ack", 32'(ia), 32'h20);
    chk("prio5_dat", 32'(d), 32'h0154);
    bus(1'b0, 8'h00, 1'b0, lat, nacks, d, d_ht, ia);
    chk("prio0_irq_ack", 32'(ia), 32'h01);
    chk("prio0_dat", 32'(d), 32'h0028);

    // Fast input read
    bus(1'b1, 8'h00, 1'b0, lat, nacks, d, d_ht, ia);
    chk("fdin_lat", 32'(lat), 32'd3);
    chk("fdin_dat", 32'(d), 32'(16'o173000));
    chk("fdin_dat_halt", 32'(d_ht), 32'(16'o173004));
    chk("fdin_irq_ack", 32'(ia), 32'h0);

    // Request withdrawn before the latch edge
    irq_lvl[4 +: 2] = 2'b00; irq_vec[16 +: 8] = 8'h33; irq_req[2] = 1'b1;
    bus(1'b0, 8'h04, 1'b0, lat, nacks, d, d_ht, ia);
    chk("stray_dat", 32'(d), 32'h0);
    chk("stray_irq_ack", 32'(ia), 32'h0);
    chk("stray_nacks", 32'(nacks), 32'd1);

    // Strobe held high well past the ack
    irq_lvl[12 +: 2] = 2'b10; irq_vec[48 +: 8] = 8'o003; irq_req[6] = 1'b1;
    bus(1'b0, 8'h00, 1'b1, lat, nacks, d, d_ht, ia);
    chk("hold_nacks", 32'(nacks), 32'd1);
    chk("hold_irq_ack", 32'(ia), 32'h40);
    chk("hold_dat", 32'(d), 32'(16'o000014));

    // Reset landing on the latch cycle
    irq_lvl[8 +: 2] = 2'b01; irq_vec[32 +: 8] = 8'h12; irq_req[4] = 1'b1;
    @(negedge clk);
    stb = 1'b1;
    @(negedge clk);
    vm_init = 1'b1; stb = 1'b0;
    @(negedge clk);
    chk("midrst_ack", 32'(ack), 32'h0);
    chk("midrst_irq_ack", 32'(iack), 32'h0);
    vm_init = 1'b0;
    nres = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack || iack != 8'h00) nres++;
    end
    chk("midrst_no_late_ack", 32'(nres), 32'd0);
    bus(1'b0, 8'h00, 1'b0, lat, nacks, d, d_ht, ia);
    chk("midrst_recover_irq_ack", 32'(ia), 32'h10);
    chk("midrst_recover_lat", 32'(lat), 32'd3);
    chk("midrst_recover_dat", 32'(d), 32'h0048);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f11_vic.md
# f11_vic

Vectored interrupt controller for the F-11 Wishbone system, sitting directly downstream of the CPU's interrupt-vector Wishbone port. It collects level-sensitive requests from peripherals, presents per-level request lines to the CPU's `vm_virq[7:4]`, and answers interrupt-acknowledge cycles with the winning source's vector. It also answers unaddressed fast-input reads with the boot/configuration word.

## Interface
Parameters:
- `N_IRQ`, 8: number of request sources, 1..16.
- `BOOT_HI`, 8'o366: fast-input word bits [15:8]; default selects start address 173000.
- `HALT_TRAP`, 0: fast-input bit 2; 1 = HALT causes trap 10, 0 = HALT enters ODT.
- `STRAY_VEC`, 16'o000000: vector returned when no request is pending at arbitration.

Ports:
- `vm_clk_p`, in, 1: clock, rising edge.
- `vm_init`, in, 1: reset, synchronous, active-high.
- `irq_req`, in, N_IRQ: level requests, held by peripheral until acknowledged.
- `irq_lvl`, in, 2*N_IRQ: per-source level; code k means BR(4+k).
- `irq_vec`, in, 8*N_IRQ: per-source vector bits [9:2].
- `irq_ack`, out, N_IRQ: one-cycle grant pulse to the winning source.
- `vm_virq`, out, [7:4]: registered per-level request lines to the CPU.
- `wbi_stb_i`, in, 1: vector/fast-input strobe from the CPU.
- `wbi_una_i`, in, 1: qualifies the strobe as a fast-input read.
- `wbi_dat_o`, out, 16: vector or fast-input data.
- `wbi_ack_o`, out, 1: acknowledge.

## Operation
- `vm_virq[L]` is the OR of `irq_req[i]` over all sources with `4+irq_lvl[i] == L`. It is registered, so it lags `irq_req` by 1 cycle.
- Arbitration picks the highest level first. Within a level, the lowest index wins. Arbitration is combinational over the live `irq_req`.
- FSM states and transitions:
  - IDLE:
    - On `wbi_stb_i & wbi_una_i`, go to FDIN.
    - On `wbi_stb_i & ~wbi_una_i`, go to LATCH.
  - LATCH: capture the winner index and a valid flag, then go to ACK.
  - FDIN: load `wbi_dat_o = {BOOT_HI, 5'b0, HALT_TRAP, 2'b00}`, then go to ACK.
  - ACK:
    - `wbi_ack_o` = 1 for exactly one cycle.
    - If this is a vector cycle and the valid flag is set: `wbi_dat_o = {6'b0, irq_vec[winner], 2'b00}` and `irq_ack[winner]` pulses in the same cycle.
    - If this is a vector cycle and the valid flag is clear: `wbi_dat_o = STRAY_VEC` and no `irq_ack` pulses.
    - Then go to WAIT.
  - WAIT: hold until `wbi_stb_i` = 0, then go to IDLE. This prevents a double acknowledge while the CPU's strobe falls.
- `wbi_dat_o` holds its last value outside ACK; its value is only defined during ACK.
- Requests that change after LATCH do not affect the vector already captured.
- A strobe held high through WAIT is never re-acknowledged. A new cycle requires the strobe to fall and rise again.
- `vm_init` during any state:
  - Next state is IDLE.
  - `wbi_ack_o`, `irq_ack` and `vm_virq` are 0.
  - `wbi_dat_o` is 0.
  - Winner/valid flags are cleared.

## Timing
- Acknowledge latency: strobe seen in IDLE at edge n → LATCH/FDIN at edge n+1 → `wbi_ack_o` high after edge n+2. This gives 2 cycles of ack latency, well inside the CPU's 64-cycle bus timer.
- `irq_ack` is coincident with `wbi_ack_o`. The peripheral must drop `irq_req` by the next cycle; `vm_virq` then follows 1 cycle later.
- Back-to-back cycles: the minimum spacing is 4 cycles (IDLE, LATCH, ACK, WAIT).
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `f11_vic_pkg` holds:
  - the state enum (IDLE, LATCH, FDIN, ACK, WAIT);
  - the level base constant (4);
  - the fast-input bit-position constants (start address [15:8], HALT bit 2).
- Sub-module `f11_vic_arb`: parameterised combinational priority encoder.
  - Inputs: `req`, `lvl`.
  - Outputs: winner index, `valid`, per-level OR.
  - Instantiated once; the top level holds the FSM and registers.

## Test plan
- Reset: `vm_init` = 1 with all `irq_req` set → all outputs 0 and state IDLE. Release reset → `vm_virq` reflects the requests 1 cycle later.
- Single request, then an acknowledge cycle:
  - Stimulus: `irq_req[3]`=1, `irq_lvl[3]`=2'b01, `irq_vec[3]`=8'o017; assert `wbi_stb_i`.
  - Before the acknowledge: `vm_virq` = 4'b0010.
  - 2 cycles after strobe: `wbi_ack_o`=1, `wbi_dat_o`=16'o000074, `irq_ack`=8'b0000_1000, each for 1 cycle.
- Priority: sources 1 and 5 at level 7, source 0 at level 4 → source 1 wins. Re-run with source 1 dropped → source 5 wins.
- Fast input with defaults: `wbi_una_i`=1, strobe asserted → `wbi_dat_o`=16'o173000, 2-cycle latency. With `HALT_TRAP`=1 → 16'o173004.
- Stray and hold:
  - A request withdrawn before LATCH → `wbi_dat_o` = `STRAY_VEC` and no `irq_ack`.
  - Strobe held high 10 cycles → exactly one ack.
- Reset mid-operation: `vm_init` asserted in the LATCH cycle → no ack, no `irq_ack`, IDLE next cycle.
